// File: rtl/seq_divider_unit.sv
// Unsigned sequential restoring divider: Q = A / B, R = A % B.
// One quotient bit is produced per clock. A zero divisor short-circuits
// straight to the result cycle with Q = all ones, R = A and div_by_zero set.
//
// Handshake: start is sampled only on an edge where busy=0 (IDLE or the
// one-cycle DONE state); A/B are captured on that same edge. done pulses for
// exactly one cycle when Q/R/div_by_zero hold a fresh result. Those outputs
// then hold until the next result. A start seen while busy=1 is ignored.
// The FSM state is fully visible on the outputs: busy=1 means CALC, done=1
// means DONE, and both low means IDLE.
module seq_divider_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] bv;
  logic [WIDTH-1:0] wq;
  logic [WIDTH:0]   wr;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_iter;
  logic             b_zero;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   d;
  logic [WIDTH-1:0] wq_nx;
  logic [WIDTH:0]   wr_nx;

  // The partial remainder always stays below the divisor, so the top bit of
  // wr is zero after every step; it only exists to hold the trial result.
  logic             unused_wr_msb;
  assign unused_wr_msb = wr[WIDTH];

  assign accept    = start && (state != CALC);
  assign b_zero    = (B == '0);
  assign last_iter = (cnt == CW'(1));

  // One restoring step: shift, trial subtract, keep or restore.
  always_comb begin
    t     = {wr[WIDTH-1:0], wq[WIDTH-1]};
    d     = t - {1'b0, bv};
    wq_nx = {wq[WIDTH-2:0], ~d[WIDTH]};
    wr_nx = d[WIDTH] ? t : d;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = b_zero ? DONE : CALC;
        else       state_next = IDLE;
      end
      CALC:    if (last_iter) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // Working registers and result registers; results move only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bv          <= '0;
      wq          <= '0;
      wr          <= '0;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      bv  <= B;
      wq  <= A;
      wr  <= '0;
      cnt <= CW'(WIDTH);
      if (b_zero) begin
        Q           <= '1;
        R           <= A;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      wq  <= wq_nx;
      wr  <= wr_nx;
      cnt <= cnt - CW'(1);
      if (last_iter) begin
        Q           <= wq_nx;
        R           <= wr_nx[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_unit.sv
// Testbench for seq_divider_unit (WIDTH=4): directed tests plus a full
// 16x16 operand sweep, checked every cycle against a cycle-count model.
module tb_seq_divider_unit;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] q_out;
  logic [W-1:0] r_out;
  logic         dz;

  int vectors    = 0;
  int miscompares = 0;
  int done_count = 0;
  int cyc        = 0;

  seq_divider_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (a_in),
    .B           (b_in),
    .busy        (busy),
    .done        (done),
    .Q           (q_out),
    .R           (r_out),
    .div_by_zero (dz)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // A non-zero-divisor operation keeps the unit busy for W cycles, then
  // shows its result for one done cycle. Pending results wait in exp_q as
  // {dz, Q, R} computed with plain / and %.
  logic [2*W:0] exp_q[$];
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_q, m_r;
  logic         m_dz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_dz   = 1'b0;
      exp_q.delete();
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        logic [2*W:0] e;
        e      = exp_q.pop_front();
        m_dz   = e[2*W];
        m_q    = e[2*W-1:W];
        m_r    = e[W-1:0];
        m_done = 1'b1;
      end else begin
        m_done = 1'b0;
      end
    end else if (start) begin
      if (b_in == 0) begin
        m_q    = {W{1'b1}};
        m_r    = a_in;
        m_dz   = 1'b1;
        m_done = 1'b1;
      end else begin
        logic [W-1:0] qq, rr;
        qq = a_in / b_in;
        rr = a_in % b_in;
        exp_q.push_back({1'b0, qq, rr});
        m_left = W;
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    vectors++;
    if (busy !== (m_left > 0) || done !== m_done || q_out !== m_q ||
        r_out !== m_r || dz !== m_dz) begin
      miscompares++;
      $display("FAIL cycle %0d: got busy=%b done=%b Q=%0d R=%0d dz=%b, want busy=%b done=%b Q=%0d R=%0d dz=%b",
               cyc, busy, done, q_out, r_out, dz, (m_left > 0), m_done, m_q, m_r, m_dz);
    end
    if (done === 1'b1) done_count++;
  end

  // ---------------- driver / literal check tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Issue one operation (start for one cycle), wait for done, count busy cycles.
  // Returns with the bench sitting on the negedge of the done cycle.
  task automatic do_op(input int a, input int b, output int busy_cycles, output int done_cyc);
    bit seen;
    busy_cycles = 0;
    done_cyc    = -1;
    seen        = 0;
    start = 1'b1;
    a_in  = W'(a);
    b_in  = W'(b);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        seen     = 1;
        done_cyc = cyc;
      end
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL timeout waiting for done on %0d/%0d", a, b);
    end
  endtask

  task automatic wait_done(input string name, output int done_cyc);
    bit seen;
    seen     = 0;
    done_cyc = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen     = 1;
        done_cyc = cyc;
      end
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL %s: timeout waiting for done", name);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc, dc, dc2, base;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_q", q_out, 0);
    chk("reset_r", r_out, 0);
    chk("reset_dz", dz, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1
    do_op(13, 4, bc, dc);
    chk("t1_busy_cycles", bc, 4);
    chk("t1_q", q_out, 3);
    chk("t1_r", r_out, 1);
    chk("t1_dz", dz, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", done, 0);
    chk("t1_q_held", q_out, 3);

    // T2
    do_op(15, 1, bc, dc);
    chk("t2a_q", q_out, 15);
    chk("t2a_r", r_out, 0);
    do_op(3, 7, bc, dc);
    chk("t2b_q", q_out, 0);
    chk("t2b_r", r_out, 3);
    do_op(0, 5, bc, dc);
    chk("t2c_q", q_out, 0);
    chk("t2c_r", r_out, 0);
    @(negedge clk);

    // T3: divide by zero, then a normal divide clears dz
    do_op(9, 0, bc, dc);
    chk("t3_busy_cycles", bc, 0);
    chk("t3_q", q_out, 15);
    chk("t3_r", r_out, 9);
    chk("t3_dz", dz, 1);
    @(negedge clk);
    do_op(8, 2, bc, dc);
    chk("t3b_q", q_out, 4);
    chk("t3b_r", r_out, 0);
    chk("t3b_dz", dz, 0);
    @(negedge clk);

    // T4: start during CALC is ignored
    base  = done_count;
    start = 1'b1;
    a_in  = 4'd14;
    b_in  = 4'd3;
    @(negedge clk);
    a_in = 4'd1;
    b_in = 4'd1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("t4", dc);
    chk("t4_q", q_out, 4);
    chk("t4_r", r_out, 2);
    repeat (8) @(negedge clk);
    chk("t4_done_pulses", done_count - base, 1);

    // T5: start held through DONE gives a back-to-back accept
    start = 1'b1;
    a_in  = 4'd7;
    b_in  = 4'd2;
    wait_done("t5a", dc);
    chk("t5a_q", q_out, 3);
    chk("t5a_r", r_out, 1);
    a_in = 4'd12;
    b_in = 4'd5;
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy_after_b2b", busy, 1);
    wait_done("t5b", dc2);
    chk("t5_gap", dc2 - dc, 5);
    chk("t5b_q", q_out, 2);
    chk("t5b_r", r_out, 2);
    @(negedge clk);

    // T6: async reset in the middle of CALC
    start = 1'b1;
    a_in  = 4'd14;
    b_in  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_q", q_out, 0);
    chk("t6_r", r_out, 0);
    chk("t6_dz", dz, 0);
    base = done_count;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_no_done", done_count - base, 0);
    do_op(10, 3, bc, dc);
    chk("t6_q_after", q_out, 3);
    chk("t6_r_after", r_out, 1);
    @(negedge clk);

    // Exhaustive sweep; the compare process checks every cycle, and the
    // division identity is checked independently here.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(a, b, bc, dc);
        if (b != 0) begin
          chk("sweep_identity", int'(q_out) * b + int'(r_out), a);
          vectors++;
          if (!(r_out < b)) begin
            miscompares++;
            $display("FAIL sweep_r_lt_b: got R=%0d, want below %0d", r_out, b);
          end
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
